alarm_controller: RTL and testbench
===================================

ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter RING_SEC, default 60, seconds an alarm rings before auto-stop (1..511).
REQ-002 Parameter SNOOZE_SEC, default 300, seconds of one snooze pause (1..511).
REQ-003 Parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event (0..3).
REQ-004 CLOCK_1s  input  1  1 s clock, rising edge; the single clock of the block.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 ENABLE  input  1  high = time running; low = time-setting mode.
REQ-007 count  input  12  current time in seconds, 0..3599, from the seconds counter.
REQ-008 ALARM_TIME  input  12  alarm time in seconds, 0..3599.
REQ-009 ALARM_ARM  input  1  level; high = alarm armed.
REQ-010 SNOOZE  input  1  level, sampled each CLOCK_1s edge; snooze request.
REQ-011 DISMISS  input  1  level, sampled each CLOCK_1s edge; stop current alarm event.
REQ-012 alarm_on  output  1  high exactly while state is RINGING.
REQ-013 state  output  2  IDLE=0, ARMED=1, RINGING=2, SNOOZING=3.
REQ-014 snooze_cnt  output  2  snoozes used in the current alarm event.
REQ-015 timer  output  9  remaining seconds in RINGING/SNOOZING minus one; 0 in IDLE/ARMED.

Function
REQ-016 All outputs and state shall be registered and update on the rising edge of CLOCK_1s only.
REQ-017 Match event: a registered prev_count shall hold last cycle's count; match = ENABLE && count==ALARM_TIME && prev_count!=count.
REQ-018 prev_count shall load count every cycle, regardless of state or ENABLE.
REQ-019 IDLE: ALARM_ARM=1 -> ARMED next edge; otherwise stay.
REQ-020 ARMED: ALARM_ARM=0 -> IDLE; else match -> RINGING with timer=RING_SEC-1, snooze_cnt=0.
REQ-021 RINGING priority, highest first: DISMISS or ALARM_ARM=0; SNOOZE; timer==0; decrement.
REQ-022 RINGING + DISMISS -> ARMED if ALARM_ARM=1, else IDLE; timer=0.
REQ-023 RINGING + SNOOZE with snooze_cnt<MAX_SNOOZE -> SNOOZING, timer=SNOOZE_SEC-1, snooze_cnt+1; with snooze_cnt==MAX_SNOOZE SNOOZE is ignored.
REQ-024 RINGING + timer==0 -> ARMED (auto-stop), timer=0.
REQ-025 SNOOZING: DISMISS or ALARM_ARM=0 -> as REQ-022; timer==0 -> RINGING, timer=RING_SEC-1; else timer-1.
REQ-026 With ENABLE=0 in RINGING or SNOOZING, state and timer shall hold; DISMISS and ALARM_ARM=0 still act.
REQ-027 A match while RINGING or SNOOZING shall be ignored; no restart of timer.
REQ-028 A count held constant at ALARM_TIME (time stopped) shall trigger at most once.
REQ-029 snooze_cnt shall hold its value in ARMED/IDLE until the next match clears it.
REQ-030 Simultaneous SNOOZE and DISMISS: DISMISS wins.

Reset
REQ-031 RESET high shall immediately force state=IDLE, alarm_on=0, snooze_cnt=0, timer=0, prev_count=0.
REQ-032 Reset asserted mid-ring shall drop alarm_on without waiting for a clock edge.
REQ-033 After RESET release, first transition occurs on the next CLOCK_1s rising edge.

Configuration
REQ-034 Macro ALARM_SNOOZE_EN defined: snooze behaviour per REQ-023/REQ-025.
REQ-035 ALARM_SNOOZE_EN undefined: SNOOZE ignored, SNOOZING unreachable, snooze_cnt constant 0, MAX_SNOOZE and SNOOZE_SEC unused.

Verification
REQ-036 ARM=1, ALARM_TIME=10, count steps 8->9->10 -> edge after count=10 gives state=2, alarm_on=1, timer=59.
REQ-037 Ringing, no input for 60 edges -> timer 59..0, then state=1, alarm_on=0.
REQ-038 Ringing, SNOOZE one cycle (SNOOZE_EN) -> state=3, timer=299, snooze_cnt=1; after 300 edges state=2, timer=59.
REQ-039 Three snoozes consumed, SNOOZE again -> stays RINGING, snooze_cnt=3; SNOOZE+DISMISS together -> state=1.
REQ-040 count frozen at 10 with ENABLE=1 after auto-stop -> no retrigger; ENABLE=0 with count=ALARM_TIME -> no trigger.
REQ-041 RESET pulse mid-ring between clock edges -> alarm_on=0, state=0 immediately.

Source files
------------

// File: rtl/alarm_controller.sv
// -----------------------------------------------------------------------------
// alarm_controller
//
// Purpose:
//   Alarm-clock event controller running from the 1 s clock. It watches the
//   running time (count) for the alarm time, rings for RING_SEC seconds and
//   then stops by itself. Optionally the user may snooze a ringing alarm for
//   SNOOZE_SEC seconds, up to MAX_SNOOZE times per alarm event. DISMISS, or
//   disarming, ends the current event at any time.
//
// Configuration macro:
//   ALARM_SNOOZE_EN  defined   -> snooze support is built in.
//                    undefined -> SNOOZE is ignored, SNOOZING is unreachable,
//                                 snooze_cnt stays 0, SNOOZE_SEC and
//                                 MAX_SNOOZE have no effect.
//
// Parameters:
//   RING_SEC    seconds an alarm rings before auto-stop (1..511)
//   SNOOZE_SEC  seconds of one snooze pause (1..511)
//   MAX_SNOOZE  snoozes allowed per alarm event (0..3)
//
// Ports:
//   CLOCK_1s    in   1   1 s clock, rising edge, the only clock
//   RESET       in   1   asynchronous active-high reset
//   ENABLE      in   1   1 = time running, 0 = time-setting mode
//   count       in  12   current time in seconds (0..3599)
//   ALARM_TIME  in  12   alarm time in seconds (0..3599)
//   ALARM_ARM   in   1   level, 1 = alarm armed
//   SNOOZE      in   1   level, snooze request
//   DISMISS     in   1   level, end the current alarm event
//   alarm_on    out  1   high exactly while ringing
//   state       out  2   IDLE=0, ARMED=1, RINGING=2, SNOOZING=3
//   snooze_cnt  out  2   snoozes used in the current alarm event
//   timer       out  9   remaining seconds minus one while ringing/snoozing,
//                        0 otherwise
// -----------------------------------------------------------------------------
module alarm_controller #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic        CLOCK_1s,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [11:0] count,
    input  logic [11:0] ALARM_TIME,
    input  logic        ALARM_ARM,
    input  logic        SNOOZE,
    input  logic        DISMISS,
    output logic        alarm_on,
    output logic [1:0]  state,
    output logic [1:0]  snooze_cnt,
    output logic [8:0]  timer
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_RINGING  = 2'd2;
    localparam logic [1:0] ST_SNOOZING = 2'd3;

    // Timer counts down to zero, so a period of N seconds loads N-1.
    localparam logic [8:0] RING_LOAD = 9'(RING_SEC - 1);

    // Registered state and outputs
    logic [1:0]  r_state;
    logic [8:0]  r_timer;
    logic [1:0]  r_snooze_cnt;
    logic        r_alarm_on;
    logic [11:0] r_prev_count;

    // Next-state / next-output values
    logic [1:0]  w_next_state;
    logic [8:0]  w_next_timer;
    logic [1:0]  w_next_snooze_cnt;
    logic        w_next_alarm_on;

    // Decoded conditions
    logic        w_match;
    logic        w_leave;
    logic [1:0]  w_leave_state;
    logic        w_snooze_ok;
    logic        w_timer_zero;

    // A match needs the time to have just arrived at ALARM_TIME: a clock that
    // is stopped on the alarm time must not keep re-triggering.
    assign w_match = ENABLE && (count == ALARM_TIME) && (r_prev_count != count);

    // Dismiss or disarm ends an event even in time-setting mode.
    assign w_leave       = DISMISS || !ALARM_ARM;
    assign w_leave_state = ALARM_ARM ? ST_ARMED : ST_IDLE;

    assign w_timer_zero  = (r_timer == 9'd0);

`ifdef ALARM_SNOOZE_EN
    localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SEC - 1);
    localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

    // Snooze only counts while time runs and the per-event budget remains.
    assign w_snooze_ok = SNOOZE && ENABLE && (r_snooze_cnt < SNOOZE_MAX);
`else
    logic w_unused_snooze_cfg;

    assign w_snooze_ok         = 1'b0;
    // Snooze-related inputs and parameters are deliberately not used here.
    assign w_unused_snooze_cfg = SNOOZE & (SNOOZE_SEC != 32'sd0) & (MAX_SNOOZE != 32'sd0);
`endif

    // State register plus registered outputs; reset acts without a clock edge.
    always_ff @(posedge CLOCK_1s or posedge RESET) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_timer      <= 9'd0;
            r_snooze_cnt <= 2'd0;
            r_alarm_on   <= 1'b0;
            r_prev_count <= 12'd0;
        end else begin
            r_state      <= w_next_state;
            r_timer      <= w_next_timer;
            r_snooze_cnt <= w_next_snooze_cnt;
            r_alarm_on   <= w_next_alarm_on;
            r_prev_count <= count;
        end
    end

    // Next-state decision; priority inside RINGING: leave, hold, snooze, expiry.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ALARM_ARM) begin
                    w_next_state = ST_ARMED;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (!ALARM_ARM) begin
                    w_next_state = ST_IDLE;
                end else if (w_match) begin
                    w_next_state = ST_RINGING;
                end else begin
                    w_next_state = ST_ARMED;
                end
            end
            ST_RINGING: begin
                if (w_leave) begin
                    w_next_state = w_leave_state;
                end else if (!ENABLE) begin
                    w_next_state = ST_RINGING;
                end else if (w_snooze_ok) begin
                    w_next_state = ST_SNOOZING;
                end else if (w_timer_zero) begin
                    w_next_state = ST_ARMED;
                end else begin
                    w_next_state = ST_RINGING;
                end
            end
            ST_SNOOZING: begin
`ifdef ALARM_SNOOZE_EN
                if (w_leave) begin
                    w_next_state = w_leave_state;
                end else if (!ENABLE) begin
                    w_next_state = ST_SNOOZING;
                end else if (w_timer_zero) begin
                    w_next_state = ST_RINGING;
                end else begin
                    w_next_state = ST_SNOOZING;
                end
`else
                // Unreachable without snooze support; recover to a safe state.
                w_next_state = ST_IDLE;
`endif
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Next timer / snooze count / alarm_on, keyed off the chosen transition.
    always_comb begin
        w_next_timer      = r_timer;
        w_next_snooze_cnt = r_snooze_cnt;
        case (r_state)
            ST_IDLE: begin
                w_next_timer = 9'd0;
            end
            ST_ARMED: begin
                if (w_next_state == ST_RINGING) begin
                    w_next_timer      = RING_LOAD;
                    w_next_snooze_cnt = 2'd0;
                end else begin
                    w_next_timer = 9'd0;
                end
            end
            ST_RINGING: begin
                if (w_next_state == ST_SNOOZING) begin
`ifdef ALARM_SNOOZE_EN
                    w_next_timer      = SNOOZE_LOAD;
                    w_next_snooze_cnt = r_snooze_cnt + 2'd1;
`else
                    w_next_timer = 9'd0;
`endif
                end else if (w_next_state != ST_RINGING) begin
                    w_next_timer = 9'd0;
                end else if (ENABLE) begin
                    // Staying while enabled implies the timer is non-zero.
                    w_next_timer = r_timer - 9'd1;
                end else begin
                    w_next_timer = r_timer;
                end
            end
            ST_SNOOZING: begin
                if (w_next_state == ST_RINGING) begin
                    w_next_timer = RING_LOAD;
                end else if (w_next_state != ST_SNOOZING) begin
                    w_next_timer = 9'd0;
                end else if (ENABLE) begin
                    w_next_timer = r_timer - 9'd1;
                end else begin
                    w_next_timer = r_timer;
                end
            end
            default: begin
                w_next_timer = 9'd0;
            end
        endcase
`ifndef ALARM_SNOOZE_EN
        w_next_snooze_cnt = 2'd0;
`endif
        w_next_alarm_on = (w_next_state == ST_RINGING);
    end

    assign alarm_on   = r_alarm_on;
    assign state      = r_state;
    assign snooze_cnt = r_snooze_cnt;
    assign timer      = r_timer;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed scenarios with literal
// expectations, then randomized stimulus compared every cycle against a
// behavioural model that tracks "seconds left" in the current ring/snooze.
module tb_alarm_controller;

    localparam int RING = 60;
    localparam int SNZ  = 300;
    localparam int MAXS = 3;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] cnt;
    logic [11:0] atime;
    logic        arm;
    logic        snz;
    logic        dis;
    logic        alarm_on;
    logic [1:0]  state;
    logic [1:0]  snooze_cnt;
    logic [8:0]  timer;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_on = 1'b0;

    // Model: mode 0 idle, 1 armed, 2 ringing, 3 snoozing; left = seconds left.
    int m_mode = 0;
    int m_left = 0;
    int m_snz  = 0;
    int m_prev = 0;
    bit hit;
    bit quit;

    alarm_controller #(
        .RING_SEC  (RING),
        .SNOOZE_SEC(SNZ),
        .MAX_SNOOZE(MAXS)
    ) dut (
        .CLOCK_1s  (clk),
        .RESET     (rst),
        .ENABLE    (en),
        .count     (cnt),
        .ALARM_TIME(atime),
        .ALARM_ARM (arm),
        .SNOOZE    (snz),
        .DISMISS   (dis),
        .alarm_on  (alarm_on),
        .state     (state),
        .snooze_cnt(snooze_cnt),
        .timer     (timer)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference model
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0;
            m_left = 0;
            m_snz  = 0;
            m_prev = 0;
        end else begin
            hit  = en && (int'(cnt) == int'(atime)) && (m_prev != int'(cnt));
            quit = dis || !arm;
            if (m_mode == 0) begin
                if (arm) m_mode = 1;
            end else if (m_mode == 1) begin
                if (!arm) m_mode = 0;
                else if (hit) begin
                    m_mode = 2; m_left = RING; m_snz = 0;
                end
            end else if (quit) begin
                m_mode = arm ? 1 : 0;
                m_left = 0;
            end else if (en) begin
                if (m_mode == 2 && SNZ_EN && snz && m_snz < MAXS) begin
                    m_mode = 3; m_left = SNZ; m_snz = m_snz + 1;
                end else if (m_left == 1) begin
                    if (m_mode == 2) begin
                        m_mode = 1; m_left = 0;
                    end else begin
                        m_mode = 2; m_left = RING;
                    end
                end else begin
                    m_left = m_left - 1;
                end
            end
            m_prev = int'(cnt);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (check_on) begin
            check("state", int'(state), m_mode);
            check("alarm_on", int'(alarm_on), (m_mode == 2) ? 1 : 0);
            check("snooze_cnt", int'(snooze_cnt), m_snz);
            check("timer", int'(timer), (m_mode >= 2) ? m_left - 1 : 0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cnt = 12'd0; atime = 12'd0;
        arm = 1'b0; snz = 1'b0; dis = 1'b0;
        tick();
        tick();
        check("rst_state", int'(state), 0);
        check("rst_alarm", int'(alarm_on), 0);
        check("rst_timer", int'(timer), 0);
        check("rst_snz", int'(snooze_cnt), 0);
        check_on = 1'b1;

        // Count steps 8 -> 9 -> 10 with alarm at 10
        rst = 1'b0; arm = 1'b1; en = 1'b1; atime = 12'd10; cnt = 12'd8;
        tick();
        check("armed", int'(state), 1);
        cnt = 12'd9;
        tick();
        cnt = 12'd10;
        tick();
        check("ring_state", int'(state), 2);
        check("ring_alarm", int'(alarm_on), 1);
        check("ring_timer", int'(timer), 59);

        // Ring out with count frozen at the alarm time
        repeat (59) tick();
        check("ring_last_timer", int'(timer), 0);
        check("ring_last_state", int'(state), 2);
        tick();
        check("autostop_state", int'(state), 1);
        check("autostop_alarm", int'(alarm_on), 0);
        repeat (5) tick();
        check("frozen_no_retrig", int'(state), 1);

        // Time-setting mode never triggers, and prev_count keeps tracking
        en = 1'b0; cnt = 12'd9;
        tick();
        cnt = 12'd10;
        tick();
        check("disabled_no_trig", int'(state), 1);
        en = 1'b1;
        tick();
        check("reenable_no_trig", int'(state), 1);

        // Retrigger, then asynchronous reset between edges
        cnt = 12'd11;
        tick();
        cnt = 12'd10;
        tick();
        check("retrig_state", int'(state), 2);
        check("retrig_timer", int'(timer), 59);
        repeat (3) tick();
        check("count_down", int'(timer), 56);
        #2 rst = 1'b1;
        #1;
        check("async_alarm", int'(alarm_on), 0);
        check("async_state", int'(state), 0);
        #1 rst = 1'b0;
        tick();
        check("post_rst_state", int'(state), 1);

`ifdef ALARM_SNOOZE_EN
        cnt = 12'd11;
        tick();
        cnt = 12'd10;
        tick();
        snz = 1'b1;
        tick();
        check("snz_state", int'(state), 3);
        check("snz_timer", int'(timer), 299);
        check("snz_cnt", int'(snooze_cnt), 1);
        snz = 1'b0;
        repeat (300) tick();
        check("snz_back_state", int'(state), 2);
        check("snz_back_timer", int'(timer), 59);
        for (int k = 0; k < 2; k++) begin
            snz = 1'b1;
            tick();
            snz = 1'b0;
            repeat (300) tick();
        end
        check("snz3_cnt", int'(snooze_cnt), 3);
        snz = 1'b1;
        tick();
        check("snz_ignored_state", int'(state), 2);
        check("snz_ignored_timer", int'(timer), 58);
        dis = 1'b1;
        tick();
        check("snz_dis_state", int'(state), 1);
        check("snz_dis_cnt", int'(snooze_cnt), 3);
        snz = 1'b0; dis = 1'b0;
`endif

        // Randomized phase: small count range so matches are frequent
        cnt = 12'd0;
        for (int i = 0; i < 4000; i++) begin
            int r;
            if (i % 500 == 0) atime = 12'($urandom_range(0, 19));
            arm = ($urandom_range(0, 99) < 99);
            en  = ($urandom_range(0, 99) < 92);
            snz = ($urandom_range(0, 99) < 3);
            dis = ($urandom_range(0, 99) < 1);
            r = $urandom_range(0, 99);
            if (r < 60)      cnt = 12'((int'(cnt) + 1) % 20);
            else if (r < 85) cnt = cnt;
            else             cnt = 12'($urandom_range(0, 19));
            if ($urandom_range(0, 999) < 3) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
